// File: rtl/am386_bus_responder_pkg.sv
// Shared bus-cycle definitions for the Am386SX local-bus slave engine.
// Cycle-type vectors are raw pin levels {M/IO#, D/C#, W/R#}.
package am386_bus_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T2   = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_TERM = 3'd4
  } bus_state_e;

  // Halt and shutdown share this encoding; only the address tells them apart.
  localparam logic [2:0] CYC_HALT_SHUTDOWN = 3'b101;

  function automatic logic is_special_cycle(input logic [2:0] cyc);
    return cyc == CYC_HALT_SHUTDOWN;
  endfunction

endpackage

// File: rtl/am386_bus_responder_phase_gen.sv
// Processor-clock phase tracker for the CLK2 domain. Reset aligns phase to 0,
// so the second clk edge after release is the first bus edge.
module am386_phase_gen (
  input  logic clk,
  input  logic reset,
  output logic bus_edge
);

  logic phase_reg;

  always_ff @(posedge clk) begin
    if (reset) phase_reg <= 1'b0;
    else       phase_reg <= ~phase_reg;
  end

  assign bus_edge = phase_reg;

endmodule

// File: rtl/am386_bus_responder.sv
// Am386SX slave bus-cycle engine: decodes ADS#, issues one backend request per
// cycle, and always terminates with READY# (ack, timeout, or special cycle).
module am386_bus_responder
  import am386_bus_responder_pkg::*;
#(
  parameter int          WAIT_STATES = 2,
  parameter int          TIMEOUT     = 64,
  parameter logic [15:0] ERR_DATA    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ads_n,
  input  logic        w_r_n,
  input  logic        d_c_n,
  input  logic        m_io_n,
  input  logic [1:0]  be_n,
  input  logic [22:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        ready_n,
  output logic        na_n,
  output logic        req_valid,
  output logic        req_write,
  output logic        req_mio,
  output logic [22:0] req_addr,
  output logic [1:0]  req_be,
  output logic [15:0] req_wdata,
  input  logic        req_ack,
  input  logic [15:0] rsp_rdata,
  output logic        special_cyc,
  output logic        bus_error,
  output logic        busy
);

  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT);
  localparam logic [3:0] WAIT_LOAD    = 4'(WAIT_STATES);

  logic       bus_edge;
  bus_state_e state_reg, state_next;

  logic [15:0] data_out_reg, data_out_next;
  logic        data_oe_reg, data_oe_next;
  logic        ready_n_reg, ready_n_next;
  logic        req_valid_reg, req_valid_next;
  logic [22:0] req_addr_reg, req_addr_next;
  logic [1:0]  req_be_reg, req_be_next;
  logic [15:0] req_wdata_reg, req_wdata_next;
  logic [2:0]  cyc_reg, cyc_next;
  logic [7:0]  tmo_reg, tmo_next;
  logic [3:0]  wcnt_reg, wcnt_next;
  logic        timed_out_reg, timed_out_next;
  logic        special_cyc_reg, special_cyc_next;
  logic        bus_error_reg, bus_error_next;

  logic [2:0] cyc_in;
  logic       term_release, accept, timeout_hit;

  am386_phase_gen u_phase_gen (
    .clk      (clk),
    .reset    (reset),
    .bus_edge (bus_edge)
  );

  assign cyc_in       = {m_io_n, d_c_n, w_r_n};
  // The READY#-release edge doubles as an IDLE edge so back-to-back cycles lose no clock.
  assign term_release = (state_reg == ST_TERM) && bus_edge && !ready_n_reg;
  assign accept       = bus_edge && !ads_n && ((state_reg == ST_IDLE) || term_release);
  assign timeout_hit  = bus_edge && (tmo_reg <= 8'd1);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_IDLE;
      ST_T2:   if (bus_edge) state_next = ST_REQ;
      // Ack is checked first so it wins over a coincident timeout.
      ST_REQ:  if (req_ack) state_next = ST_WAIT;
               else if (timeout_hit) state_next = ST_TERM;
      ST_WAIT: if (bus_edge && (wcnt_reg == 4'd0)) state_next = ST_TERM;
      ST_TERM: if (term_release) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (accept) state_next = is_special_cycle(cyc_in) ? ST_TERM : ST_T2;
  end

  always_comb begin
    data_out_next    = data_out_reg;
    data_oe_next     = data_oe_reg;
    ready_n_next     = ready_n_reg;
    req_valid_next   = req_valid_reg;
    req_addr_next    = req_addr_reg;
    req_be_next      = req_be_reg;
    req_wdata_next   = req_wdata_reg;
    cyc_next         = cyc_reg;
    tmo_next         = tmo_reg;
    wcnt_next        = wcnt_reg;
    timed_out_next   = timed_out_reg;
    special_cyc_next = 1'b0;
    bus_error_next   = 1'b0;
    case (state_reg)
      ST_T2: if (bus_edge) begin
        if (cyc_reg[0]) req_wdata_next = data_in;
        req_valid_next = 1'b1;
        tmo_next       = TIMEOUT_LOAD;
      end
      ST_REQ: if (req_ack) begin
        req_valid_next = 1'b0;
        wcnt_next      = WAIT_LOAD;
        if (!cyc_reg[0]) begin
          data_out_next = rsp_rdata;
          data_oe_next  = 1'b1;
        end
      end else if (timeout_hit) begin
        req_valid_next = 1'b0;
        timed_out_next = 1'b1;
        if (!cyc_reg[0]) begin
          data_out_next = ERR_DATA;
          data_oe_next  = 1'b1;
        end
      end else if (bus_edge) begin
        tmo_next = tmo_reg - 8'd1;
      end
      ST_WAIT: if (bus_edge && (wcnt_reg != 4'd0)) wcnt_next = wcnt_reg - 4'd1;
      ST_TERM: if (bus_edge) begin
        if (ready_n_reg) begin
          ready_n_next = 1'b0;
        end else begin
          ready_n_next     = 1'b1;
          data_oe_next     = 1'b0;
          special_cyc_next = is_special_cycle(cyc_reg);
          bus_error_next   = timed_out_reg;
          timed_out_next   = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      req_addr_next = addr;
      req_be_next   = ~be_n;
      cyc_next      = cyc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_reg    <= '0;
      data_oe_reg     <= 1'b0;
      ready_n_reg     <= 1'b1;
      req_valid_reg   <= 1'b0;
      req_addr_reg    <= '0;
      req_be_reg      <= '0;
      req_wdata_reg   <= '0;
      cyc_reg         <= '0;
      tmo_reg         <= '0;
      wcnt_reg        <= '0;
      timed_out_reg   <= 1'b0;
      special_cyc_reg <= 1'b0;
      bus_error_reg   <= 1'b0;
    end else begin
      data_out_reg    <= data_out_next;
      data_oe_reg     <= data_oe_next;
      ready_n_reg     <= ready_n_next;
      req_valid_reg   <= req_valid_next;
      req_addr_reg    <= req_addr_next;
      req_be_reg      <= req_be_next;
      req_wdata_reg   <= req_wdata_next;
      cyc_reg         <= cyc_next;
      tmo_reg         <= tmo_next;
      wcnt_reg        <= wcnt_next;
      timed_out_reg   <= timed_out_next;
      special_cyc_reg <= special_cyc_next;
      bus_error_reg   <= bus_error_next;
    end
  end

  assign data_out    = data_out_reg;
  assign data_oe     = data_oe_reg;
  assign ready_n     = ready_n_reg;
  assign na_n        = 1'b1;
  assign req_valid   = req_valid_reg;
  assign req_write   = cyc_reg[0];
  assign req_mio     = cyc_reg[2];
  assign req_addr    = req_addr_reg;
  assign req_be      = req_be_reg;
  assign req_wdata   = req_wdata_reg;
  assign special_cyc = special_cyc_reg;
  assign bus_error   = bus_error_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule
